imem_loader: RTL and testbench

Byte-stream program loader that writes instruction words into the byte-addressed instruction memory, which the fetch path reads as 4 big-endian bytes per word. It accepts a framed image over a valid/ready byte interface and checks its length and XOR checksum. It holds the CPU in hold until a good image has been written. It sits between the bench/host link and the instruction memory write port.

---
 rtl/imem_loader.sv | 141 ++++++++++++++
 tb/tb_imem_loader.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Framed byte-stream loader for the instruction memory: length header, big-endian
// payload written one byte per cycle, XOR checksum gates release of the CPU.
module imem_loader #(
    parameter int BASE_ADDR = 0,
    parameter int MEM_BYTES = 72
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        cpu_hold,
    output logic        done,
    output logic        error,
    output logic [15:0] words_loaded
);

    localparam logic [17:0] CAP_BYTES = 18'(MEM_BYTES - BASE_ADDR);
    localparam logic [15:0] BASE16    = 16'(BASE_ADDR);

    typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, PAYLOAD, CHECK, DONE, ERROR} state_t;

    // Byte count is formed 18 bits wide so a large N cannot wrap under the capacity.
    function automatic logic len_too_big(input logic [15:0] n);
        logic [17:0] nbytes;
        nbytes = {n, 2'b00};
        return nbytes > CAP_BYTES;
    endfunction

    state_t      state, state_nxt;
    logic [7:0]  len_hi;
    logic [15:0] len_n;
    logic [17:0] last_idx;
    logic [15:0] byte_cnt;
    logic [7:0]  chk;
    logic        xfer, arm, last_byte;
    logic        wr_vld_p1;
    logic [15:0] wr_addr_p1;
    logic [7:0]  wr_data_p1;

    assign len_n     = {len_hi, in_data};
    assign xfer      = in_valid && in_ready;
    assign last_byte = ({2'b00, byte_cnt} == last_idx);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        arm       = 1'b0;
        done      = 1'b0;
        error     = 1'b0;
        cpu_hold  = 1'b1;
        case (state)
            IDLE: begin
                arm = start;
                if (start) state_nxt = LEN_HI;
            end
            LEN_HI: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = LEN_LO;
            end
            LEN_LO: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (len_too_big(len_n))  state_nxt = ERROR;
                    else if (len_n == 16'd0) state_nxt = CHECK;
                    else                     state_nxt = PAYLOAD;
                end
            end
            PAYLOAD: begin
                in_ready = 1'b1;
                if (in_valid && last_byte) state_nxt = CHECK;
            end
            CHECK: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = (in_data == chk) ? DONE : ERROR;
            end
            DONE: begin
                done     = 1'b1;
                cpu_hold = 1'b0;
                arm      = start;
                if (start) state_nxt = LEN_HI;
            end
            ERROR: begin
                error = 1'b1;
                arm   = start;
                if (start) state_nxt = LEN_HI;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // p0 -> p1: accepted payload byte becomes a registered memory write next cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            len_hi       <= 8'd0;
            last_idx     <= 18'd0;
            byte_cnt     <= 16'd0;
            chk          <= 8'd0;
            words_loaded <= 16'd0;
            wr_vld_p1    <= 1'b0;
            wr_addr_p1   <= BASE16;
            wr_data_p1   <= 8'd0;
        end else begin
            wr_vld_p1 <= 1'b0;
            if (arm) begin
                byte_cnt     <= 16'd0;
                chk          <= 8'd0;
                words_loaded <= 16'd0;
            end
            if (xfer) begin
                case (state)
                    LEN_HI: len_hi <= in_data;
                    LEN_LO: last_idx <= {len_n, 2'b00} - 18'd1;
                    PAYLOAD: begin
                        chk        <= chk ^ in_data;
                        byte_cnt   <= byte_cnt + 16'd1;
                        wr_vld_p1  <= 1'b1;
                        wr_addr_p1 <= BASE16 + byte_cnt;
                        wr_data_p1 <= in_data;
                        if (byte_cnt[1:0] == 2'd3) words_loaded <= words_loaded + 16'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign mem_we    = wr_vld_p1;
    assign mem_addr  = wr_addr_p1;
    assign mem_wdata = wr_data_p1;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: table of frames with expected status, plus a write
// scoreboard that checks address, data and one-cycle latency of every mem_we.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst_n, start, in_valid;
    logic [7:0]  in_data;
    logic        in_ready, mem_we, cpu_hold, done, error;
    logic [15:0] mem_addr, words_loaded;
    logic [7:0]  mem_wdata;

    always #5 clk = ~clk;

    imem_loader dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_hold(cpu_hold), .done(done), .error(error), .words_loaded(words_loaded)
    );

    typedef struct packed {
        logic [7:0]  lh, ll, ck;
        logic        gap, lenerr, ex_done, ex_err;
        logic [15:0] ex_words;
        logic [7:0]  ex_wr;
    } vec_t;

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
        logic [31:0] cyc;
    } wr_t;

    vec_t       tbl [8];
    logic [7:0] pay [8][72];
    wr_t        sb[$];
    int         n_assert = 0, n_fail = 0, cyc = 0, wr_cnt = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    // Every observed write must match the oldest accepted payload byte, one cycle later.
    function automatic void mon();
        wr_t e;
        if (mem_we === 1'b1) begin
            wr_cnt++;
            n_assert++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: addr %0h data %0h, expected no write", mem_addr, mem_wdata);
            end else begin
                e = sb.pop_front();
                if (mem_addr !== e.addr || mem_wdata !== e.data || 32'(cyc) !== e.cyc) begin
                    n_fail++;
                    $display("FAIL write: addr %0h data %0h cyc %0d, expected addr %0h data %0h cyc %0d",
                             mem_addr, mem_wdata, cyc, e.addr, e.data, e.cyc);
                end
            end
        end
    endfunction

    task automatic cycle();
        @(negedge clk);
        mon();
        @(posedge clk);
        #1 cyc++;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit is_pay, input logic [15:0] addr, input bit gap);
        bit rdy;
        int tries = 0;
        in_valid = 1'b1;
        in_data  = b;
        forever begin
            @(negedge clk);
            mon();
            rdy = in_ready;
            @(posedge clk);
            #1 cyc++;
            if (rdy) begin
                if (is_pay) sb.push_back('{addr: addr, data: b, cyc: 32'(cyc)});
                break;
            end
            tries++;
            if (tries > 16) begin
                n_assert++;
                n_fail++;
                $display("FAIL ready_timeout: in_ready %0b, expected 1", in_ready);
                break;
            end
        end
        in_valid = 1'b0;
        in_data  = 8'h5A;
        if (gap) cycle();
    endtask

    task automatic apply_vec(input int v);
        vec_t t = tbl[v];
        int   w0, nb;
        start = 1'b1;
        cycle();
        start = 1'b0;
        check($sformatf("v%0d_armed_ready", v), in_ready, 1);
        check($sformatf("v%0d_armed_status", v), {done, error, cpu_hold}, 3'b001);
        w0 = wr_cnt;
        send_byte(t.lh, 0, 16'd0, t.gap);
        send_byte(t.ll, 0, 16'd0, t.gap);
        if (t.lenerr) begin
            check($sformatf("v%0d_lenerr_now", v), {error, in_ready}, 2'b10);
        end else begin
            nb = 4 * int'({t.lh, t.ll});
            for (int i = 0; i < nb; i++) send_byte(pay[v][i], 1, 16'(i), t.gap);
            send_byte(t.ck, 0, 16'd0, t.gap);
        end
        cycle();
        check($sformatf("v%0d_done", v), done, t.ex_done);
        check($sformatf("v%0d_error", v), error, t.ex_err);
        check($sformatf("v%0d_cpu_hold", v), cpu_hold, !t.ex_done);
        check($sformatf("v%0d_words", v), words_loaded, t.ex_words);
        check($sformatf("v%0d_ready_idle", v), in_ready, 0);
        check($sformatf("v%0d_writes", v), wr_cnt - w0, t.ex_wr);
        check($sformatf("v%0d_sb_empty", v), sb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] x;
        // Good one-word frame: 8C^22^00^04 = AA.
        tbl[0] = '{lh: 8'h00, ll: 8'h01, ck: 8'hAA, gap: 0, lenerr: 0, ex_done: 1, ex_err: 0, ex_words: 16'd1, ex_wr: 8'd4};
        tbl[1] = '{lh: 8'h00, ll: 8'h01, ck: 8'h37, gap: 0, lenerr: 0, ex_done: 0, ex_err: 1, ex_words: 16'd1, ex_wr: 8'd4};
        tbl[2] = tbl[0];
        tbl[3] = '{lh: 8'h00, ll: 8'h13, ck: 8'h00, gap: 0, lenerr: 1, ex_done: 0, ex_err: 1, ex_words: 16'd0, ex_wr: 8'd0};
        tbl[4] = '{lh: 8'h00, ll: 8'h00, ck: 8'h00, gap: 0, lenerr: 0, ex_done: 1, ex_err: 0, ex_words: 16'd0, ex_wr: 8'd0};
        tbl[5] = '{lh: 8'h00, ll: 8'h00, ck: 8'h01, gap: 0, lenerr: 0, ex_done: 0, ex_err: 1, ex_words: 16'd0, ex_wr: 8'd0};
        tbl[6] = '{lh: 8'h00, ll: 8'h02, ck: 8'h88, gap: 1, lenerr: 0, ex_done: 1, ex_err: 0, ex_words: 16'd2, ex_wr: 8'd8};
        for (int v = 0; v < 8; v++)
            for (int i = 0; i < 72; i++) pay[v][i] = 8'h00;
        for (int v = 0; v < 3; v++) begin
            pay[v][0] = 8'h8C; pay[v][1] = 8'h22; pay[v][2] = 8'h00; pay[v][3] = 8'h04;
        end
        for (int i = 0; i < 8; i++) pay[6][i] = 8'((i + 1) * 8'h11);
        // Exactly-full image: 18 words = 72 bytes, checksum from a reference XOR.
        x = 8'h00;
        for (int i = 0; i < 72; i++) begin
            pay[7][i] = 8'(i * 5 + 1);
            x = x ^ pay[7][i];
        end
        tbl[7] = '{lh: 8'h00, ll: 8'h12, ck: x, gap: 0, lenerr: 0, ex_done: 1, ex_err: 0, ex_words: 16'd18, ex_wr: 8'd72};

        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        check("rst_ready", in_ready, 0);
        check("rst_we", mem_we, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_status", {cpu_hold, done, error}, 3'b100);
        check("rst_words", words_loaded, 0);
        in_valid = 1'b1;
        in_data  = 8'hC3;
        cycle();
        in_valid = 1'b0;
        check("idle_valid_ignored", {in_ready, error, done, cpu_hold}, 4'b0001);

        for (int v = 0; v < 8; v++) apply_vec(v);

        // in_valid while DONE is harmless
        in_valid = 1'b1;
        in_data  = 8'hFF;
        cycle();
        cycle();
        in_valid = 1'b0;
        check("done_valid_ignored", {done, error, in_ready}, 3'b100);

        // Reset after 5 payload bytes of a 3-word frame, with a 6th byte offered on the reset edge
        start = 1'b1;
        cycle();
        start = 1'b0;
        send_byte(8'h00, 0, 16'd0, 0);
        send_byte(8'h03, 0, 16'd0, 0);
        for (int i = 0; i < 5; i++) send_byte(8'(8'hA1 + i), 1, 16'(i), 0);
        in_valid = 1'b1;
        in_data  = 8'hEE;
        rst_n    = 1'b0;
        @(negedge clk);
        mon();
        @(posedge clk);
        #1 cyc++;
        rst_n    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        mon();
        check("midrst_we", mem_we, 0);
        check("midrst_status", {cpu_hold, done, error, in_ready}, 4'b1000);
        check("midrst_words", words_loaded, 0);
        check("midrst_sb_empty", sb.size(), 0);
        @(posedge clk);
        #1 cyc++;
        apply_vec(0);

        // start held high during PAYLOAD must not re-arm the load
        start = 1'b1;
        cycle();
        start = 1'b0;
        send_byte(8'h00, 0, 16'd0, 0);
        send_byte(8'h01, 0, 16'd0, 0);
        start = 1'b1;
        send_byte(8'h8C, 1, 16'd0, 0);
        send_byte(8'h22, 1, 16'd1, 0);
        start = 1'b0;
        send_byte(8'h00, 1, 16'd2, 0);
        send_byte(8'h04, 1, 16'd3, 0);
        send_byte(8'hAA, 0, 16'd0, 0);
        cycle();
        check("start_ignored_status", {done, error, cpu_hold}, 3'b100);
        check("start_ignored_words", words_loaded, 1);
        check("start_ignored_sb", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
